// File: rtl/barrel_pool_pkg.sv
// Shared types and default geometry for the multi-barrel engine.
// Slot state codes, game FSM codes, roll direction, bus field widths.
package barrel_pool_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'b00,
    SLOT_ROLL   = 2'b01,
    SLOT_FALL   = 2'b10,
    SLOT_FROZEN = 2'b11
  } slot_state_t;

  typedef enum logic [1:0] {
    GAME_STOP = 2'b00,
    GAME_RUN  = 2'b01,
    GAME_HALT = 2'b10
  } game_state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // Per-slot field widths on the renderer buses.
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int A_W = 3;

  // Default geometry (pixels / ticks).
  localparam int DEF_N_BARRELS      = 4;
  localparam int DEF_SPAWN_INTERVAL = 120;
  localparam int DEF_SPAWN_X        = 32;
  localparam int DEF_Y_START        = 48;
  localparam int DEF_X_MIN          = 16;
  localparam int DEF_X_MAX          = 608;
  localparam int DEF_STEP_X         = 2;
  localparam int DEF_PLATFORM_PITCH = 64;
  localparam int DEF_FALL_STEP      = 4;
  localparam int DEF_Y_FLOOR        = 432;
  localparam int DEF_ANIM_DIV       = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/barrel_pool_if.sv
// Control and renderer bus of the barrel pool.
// master: game control + sprite renderer side; slave: the barrel_pool engine.
interface barrel_pool_if #(
  parameter int N_BARRELS = 4
);
  localparam int CNT_W = $clog2(N_BARRELS + 1);

  logic                   tick;
  logic                   start;
  logic                   over;
  logic [10*N_BARRELS-1:0] x_bus;
  logic [9*N_BARRELS-1:0]  y_bus;
  logic [2*N_BARRELS-1:0]  state_bus;
  logic [3*N_BARRELS-1:0]  anim_bus;
  logic [CNT_W-1:0]        active_count;
  logic                    spawn_pulse;

  modport master (
    output tick, start, over,
    input  x_bus, y_bus, state_bus, anim_bus, active_count, spawn_pulse
  );

  modport slave (
    input  tick, start, over,
    output x_bus, y_bus, state_bus, anim_bus, active_count, spawn_pulse
  );

endinterface

// File: rtl/barrel_pool_slot.sv
// One barrel slot: position, direction, state, animation frame and divider.
// Freeze beats everything; on a tick a despawn is resolved before a spawn,
// so a slot leaving the field can be re-used in the same update.
module barrel_pool_slot
  import barrel_pool_pkg::*;
#(
  parameter int SPAWN_X        = DEF_SPAWN_X,
  parameter int Y_START        = DEF_Y_START,
  parameter int X_MIN          = DEF_X_MIN,
  parameter int X_MAX          = DEF_X_MAX,
  parameter int STEP_X         = DEF_STEP_X,
  parameter int PLATFORM_PITCH = DEF_PLATFORM_PITCH,
  parameter int FALL_STEP      = DEF_FALL_STEP,
  parameter int Y_FLOOR        = DEF_Y_FLOOR,
  parameter int ANIM_DIV       = DEF_ANIM_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            spawn,
  input  logic            freeze,
  input  logic            early_fall,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output slot_state_t     state,
  output logic [A_W-1:0]  anim,
  output logic            free,
  output slot_state_t     state_nxt
);

  localparam int DIV_W = width_of(ANIM_DIV);

  localparam logic [X_W-1:0]   XMIN     = X_W'(X_MIN);
  localparam logic [X_W-1:0]   XMAX     = X_W'(X_MAX);
  localparam logic [X_W-1:0]   XSTEP    = X_W'(STEP_X);
  localparam logic [X_W-1:0]   XSPAWN   = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0]   YSTART   = Y_W'(Y_START);
  localparam logic [Y_W:0]     YFALL    = (Y_W+1)'(FALL_STEP);
  localparam logic [Y_W:0]     YFLOOR   = (Y_W+1)'(Y_FLOOR);
  localparam logic [Y_W:0]     YPITCH   = (Y_W+1)'(PLATFORM_PITCH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  dir_t             dir, dir_n;
  logic [DIV_W-1:0] div, div_n;
  logic [Y_W-1:0]   base, base_n;
  logic [X_W-1:0]   x_n, roll_x;
  logic [Y_W-1:0]   y_n;
  logic [A_W-1:0]   anim_n;
  logic [Y_W:0]     fall_y, land_y;
  logic             at_floor;

  // Candidate positions for this tick, saturated at the roll limits.
  assign roll_x   = (dir == DIR_LEFT)
                  ? ((x <= XMIN + XSTEP) ? XMIN : x - XSTEP)
                  : ((x >= XMAX - XSTEP) ? XMAX : x + XSTEP);
  assign fall_y   = {1'b0, y} + YFALL;
  assign land_y   = {1'b0, base} + YPITCH;
  assign at_floor = fall_y >= YFLOOR;

  // Slot is spawnable when idle or about to drop off the floor this tick.
  assign free = (state == SLOT_IDLE) || ((state == SLOT_FALL) && at_floor);

  // Next-state computation for the whole slot.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    x_n       = x;
    y_n       = y;
    state_nxt = state;
    anim_n    = anim;
    div_n     = div;
    dir_n     = dir;
    base_n    = base;
    if (freeze) begin
      if (state != SLOT_IDLE) state_nxt = SLOT_FROZEN;
    end else if (tick) begin
      case (state)
        SLOT_ROLL: begin
          if (early_fall) begin
            state_nxt = SLOT_FALL;
            anim_n    = '1;
            base_n    = y;
          end else begin
            x_n = roll_x;
            if (roll_x == XMIN || roll_x == XMAX) begin
              state_nxt = SLOT_FALL;
              anim_n    = '1;
              base_n    = y;
            end else if (div == DIV_LAST) begin
              div_n  = '0;
              anim_n = anim + 1'b1;
            end else begin
              div_n = div + 1'b1;
            end
          end
        end
        SLOT_FALL: begin
          anim_n = '1;
          if (at_floor) begin
            state_nxt = SLOT_IDLE;
            x_n       = '0;
            y_n       = '0;
            anim_n    = '0;
            div_n     = '0;
            dir_n     = DIR_RIGHT;
          end else begin
            y_n = fall_y[Y_W-1:0];
            if (fall_y >= land_y) begin
              state_nxt = SLOT_ROLL;
              dir_n     = (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
              div_n     = '0;
            end
          end
        end
        default: ;
      endcase
      if (spawn) begin
        x_n       = XSPAWN;
        y_n       = YSTART;
        state_nxt = SLOT_ROLL;
        dir_n     = DIR_RIGHT;
        anim_n    = '0;
        div_n     = '0;
        base_n    = YSTART;
      end
    end
  end

  // Slot registers; these drive the renderer buses directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      state <= SLOT_IDLE;
      anim  <= '0;
      div   <= '0;
      dir   <= DIR_RIGHT;
      base  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      x     <= x_n;
      y     <= y_n;
      state <= state_nxt;
      anim  <= anim_n;
      div   <= div_n;
      dir   <= dir_n;
      base  <= base_n;
    end
  end

endmodule

// File: rtl/barrel_pool.sv
// Multi-barrel engine: game FSM, spawn timer, lowest-idle spawn priority,
// N barrel_pool_slot instances, active-slot popcount.
// Optional feature macro: BARREL_POOL_LADDER_EN (LFSR-driven ladder descents).
module barrel_pool
  import barrel_pool_pkg::*;
#(
  parameter int N_BARRELS      = DEF_N_BARRELS,
  parameter int SPAWN_INTERVAL = DEF_SPAWN_INTERVAL,
  parameter int SPAWN_X        = DEF_SPAWN_X,
  parameter int Y_START        = DEF_Y_START,
  parameter int X_MIN          = DEF_X_MIN,
  parameter int X_MAX          = DEF_X_MAX,
  parameter int STEP_X         = DEF_STEP_X,
  parameter int PLATFORM_PITCH = DEF_PLATFORM_PITCH,
  parameter int FALL_STEP      = DEF_FALL_STEP,
  parameter int Y_FLOOR        = DEF_Y_FLOOR,
  parameter int ANIM_DIV       = DEF_ANIM_DIV
) (
  input logic          clk,
  input logic          rst_n,
  barrel_pool_if.slave bus
);

  localparam int CNT_W = $clog2(N_BARRELS + 1);
  localparam int TMR_W = width_of(SPAWN_INTERVAL);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SPAWN_INTERVAL - 1);

  game_state_t          game;
  logic [TMR_W-1:0]     timer;
  logic                 freeze, spawn_ok, spawn_fire;
  logic [N_BARRELS-1:0] free, grant, early_fall;
  logic [CNT_W-1:0]     cnt_nxt;

  logic [X_W-1:0] sx [N_BARRELS];
  logic [Y_W-1:0] sy [N_BARRELS];
  logic [A_W-1:0] sa [N_BARRELS];
  slot_state_t    ss [N_BARRELS];
  slot_state_t    sn [N_BARRELS];

  // over in RUN freezes in the same update it is seen, ahead of any motion.
  assign freeze     = ((game == GAME_RUN) && bus.over) || (game == GAME_HALT);
  assign spawn_ok   = bus.tick && (game == GAME_RUN) && !bus.over && (timer == '0);
  assign spawn_fire = spawn_ok && (|free);

  // Game FSM and spawn timer; the timer wraps whether or not a spawn succeeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game  <= GAME_STOP;
      timer <= '0;
    end else begin
      case (game)
        GAME_STOP: if (bus.start && !bus.over) game <= GAME_RUN;
        GAME_RUN: begin
          if (bus.over) game <= GAME_HALT;
          else if (bus.tick) timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lowest-index free slot wins the spawn.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_BARRELS; i++) begin
      if (free[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Count of slots that will be non-idle after this clock.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < N_BARRELS; i++)
      cnt_nxt = cnt_nxt + CNT_W'(sn[i] != SLOT_IDLE);
  end

  // Registered status outputs, aligned with the slot update they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.spawn_pulse  <= 1'b0;
      bus.active_count <= '0;
    end else begin
      bus.spawn_pulse  <= spawn_fire;
      bus.active_count <= cnt_nxt;
    end
  end

`ifdef BARREL_POOL_LADDER_EN
  localparam logic [X_W-1:0] XMIN = X_W'(X_MIN);
  localparam logic [X_W-1:0] XMAX = X_W'(X_MAX);
  logic [7:0] lfsr;

  // Ladder LFSR (x^8+x^6+x^5+x^4+1), advancing once per frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lfsr <= 8'hA5;
    else if (bus.tick) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

  for (genvar i = 0; i < N_BARRELS; i++) begin : g_slot
`ifdef BARREL_POOL_LADDER_EN
    // Ladder descent at every 64th x away from the roll limits.
    assign early_fall[i] = (lfsr[1:0] == 2'b00) && (sx[i][5:0] == 6'd0) &&
                           (sx[i] != XMIN) && (sx[i] != XMAX);
`else
    assign early_fall[i] = 1'b0;
`endif

    barrel_pool_slot #(
      .SPAWN_X        (SPAWN_X),
      .Y_START        (Y_START),
      .X_MIN          (X_MIN),
      .X_MAX          (X_MAX),
      .STEP_X         (STEP_X),
      .PLATFORM_PITCH (PLATFORM_PITCH),
      .FALL_STEP      (FALL_STEP),
      .Y_FLOOR        (Y_FLOOR),
      .ANIM_DIV       (ANIM_DIV)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (bus.tick),
      .spawn      (spawn_ok && grant[i]),
      .freeze     (freeze),
      .early_fall (early_fall[i]),
      .x          (sx[i]),
      .y          (sy[i]),
      .state      (ss[i]),
      .anim       (sa[i]),
      .free       (free[i]),
      .state_nxt  (sn[i])
    );

    assign bus.x_bus[X_W*i +: X_W]  = sx[i];
    assign bus.y_bus[Y_W*i +: Y_W]  = sy[i];
    assign bus.state_bus[2*i +: 2]  = ss[i];
    assign bus.anim_bus[A_W*i +: A_W] = sa[i];
  end

endmodule

// File: tb/tb_barrel_pool.sv
// Directed bench for barrel_pool (default build, 4 slots, default geometry).
// Expected positions are hand-derived from the geometry along the tick timeline.
module tb_barrel_pool;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   tick_n = 0;

  barrel_pool_if #(.N_BARRELS(4)) bus ();

  barrel_pool #(.N_BARRELS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] xs(input int i);
    return bus.x_bus[10*i +: 10];
  endfunction
  function automatic logic [8:0] ys(input int i);
    return bus.y_bus[9*i +: 9];
  endfunction
  function automatic logic [1:0] st(input int i);
    return bus.state_bus[2*i +: 2];
  endfunction
  function automatic logic [2:0] an(input int i);
    return bus.anim_bus[3*i +: 3];
  endfunction

  // One frame tick: strobe for exactly one clock, outputs sampled on the falling edge after.
  task automatic tick_once();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    if (bus.spawn_pulse) pulses++;
  endtask

  task automatic run_to(input int target);
    while (tick_n < target) begin
      tick_once();
      tick_n++;
    end
  endtask

  initial begin
    int changes;
    int idle_pulses;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.over  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_x",     bus.x_bus, 40'd0);
    check("rst_y",     bus.y_bus, 40'd0);
    check("rst_state", bus.state_bus, 40'd0);
    check("rst_anim",  bus.anim_bus, 40'd0);
    check("rst_count", bus.active_count, 40'd0);
    check("rst_pulse", bus.spawn_pulse, 40'd0);

    // start and over together in STOP: stays stopped, no spawn
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.over  = 1'b1;
    tick_once();
    check("stop_both_count", bus.active_count, 40'd0);
    check("stop_both_state", bus.state_bus, 40'd0);
    bus.over = 1'b0;

    // T1: first tick in RUN spawns slot 0
    run_to(1);
    check("t1_x0",     xs(0), 40'd32);
    check("t1_y0",     ys(0), 40'd48);
    check("t1_st0",    st(0), 40'd1);
    check("t1_anim0",  an(0), 40'd0);
    check("t1_pulse",  bus.spawn_pulse, 40'd1);
    check("t1_count",  bus.active_count, 40'd1);
    @(negedge clk);
    check("t1_pulse_1clk", bus.spawn_pulse, 40'd0);

    // Animation divider: one frame every 4 roll ticks
    run_to(5);
    check("anim_x0",   xs(0), 40'd40);
    check("anim_a0",   an(0), 40'd1);

    // T2: reaches X_MAX after 288 more ticks, falls 16 ticks, then rolls left
    run_to(289);
    check("t2_xmax",   xs(0), 40'd608);
    check("t2_fall",   st(0), 40'd2);
    run_to(297);
    check("t2_fall_y",    ys(0), 40'd80);
    check("t2_fall_anim", an(0), 40'd7);
    run_to(305);
    check("t2_land_y",  ys(0), 40'd112);
    check("t2_land_st", st(0), 40'd1);
    run_to(306);
    check("t2_left_x",  xs(0), 40'd606);

    // T3: slots fill at ticks 1,121,241,361; tick 481 finds no idle slot
    run_to(361);
    check("t3_st3",    st(3), 40'd1);
    check("t3_x3",     xs(3), 40'd32);
    check("t3_count",  bus.active_count, 40'd4);
    run_to(481);
    check("t3_full_pulse", bus.spawn_pulse, 40'd0);
    check("t3_full_count", bus.active_count, 40'd4);
    check("t3_pulses",     pulses, 40'd4);
    check("t3_x1",         xs(1), 40'd496);
    check("t3_y1",         ys(1), 40'd112);

    // Slot 0 drops off the floor from the y=368 platform at tick 1865
    run_to(1864);
    check("floor_pre_y",  ys(0), 40'd428);
    check("floor_pre_st", st(0), 40'd2);
    run_to(1865);
    check("despawn_st",    st(0), 40'd0);
    check("despawn_x",     xs(0), 40'd0);
    check("despawn_y",     ys(0), 40'd0);
    check("despawn_count", bus.active_count, 40'd3);

    // Next spawn slot (tick 1921) re-uses slot 0
    run_to(1921);
    check("respawn_x0",    xs(0), 40'd32);
    check("respawn_st0",   st(0), 40'd1);
    check("respawn_pulse", bus.spawn_pulse, 40'd1);
    check("respawn_count", bus.active_count, 40'd4);
    check("respawn_x1",    xs(1), 40'd112);
    check("respawn_y1",    ys(1), 40'd368);

    // T4: over arrives with a tick; freeze wins, positions hold, start ignored
    @(negedge clk);
    bus.tick = 1'b1;
    bus.over = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("t4_state",   bus.state_bus, 40'hFF);
    check("t4_x0",      xs(0), 40'd32);
    check("t4_x1",      xs(1), 40'd112);
    check("t4_pulse",   bus.spawn_pulse, 40'd0);
    for (int i = 0; i < 100; i++) begin
      bus.start = i[0];
      tick_once();
    end
    check("t4_hold_state", bus.state_bus, 40'hFF);
    check("t4_hold_x0",    xs(0), 40'd32);
    check("t4_hold_y0",    ys(0), 40'd48);
    check("t4_hold_a0",    an(0), 40'd0);
    check("t4_hold_x1",    xs(1), 40'd112);
    check("t4_hold_y1",    ys(1), 40'd368);
    check("t4_hold_count", bus.active_count, 40'd4);

    // T5: asynchronous reset between clock edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_x",     bus.x_bus, 40'd0);
    check("t5_y",     bus.y_bus, 40'd0);
    check("t5_state", bus.state_bus, 40'd0);
    check("t5_anim",  bus.anim_bus, 40'd0);
    check("t5_count", bus.active_count, 40'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.over  = 1'b0;
    bus.start = 1'b1;
    tick_n    = 0;
    run_to(1);
    check("t5_x0",    xs(0), 40'd32);
    check("t5_y0",    ys(0), 40'd48);
    check("t5_st",    bus.state_bus, 40'd1);
    check("t5_pulse", bus.spawn_pulse, 40'd1);
    check("t5_count", bus.active_count, 40'd1);

    // T6: tick held low for 1000 clocks in RUN
    changes     = 0;
    idle_pulses = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.spawn_pulse) idle_pulses++;
      if (bus.x_bus !== 40'd32 || bus.y_bus !== 36'd48 ||
          bus.state_bus !== 8'h01 || bus.anim_bus !== 12'd0 ||
          bus.active_count !== 3'd1)
        changes++;
    end
    check("t6_changes", changes, 40'd0);
    check("t6_pulses",  idle_pulses, 40'd0);
    run_to(2);
    check("t6_x0",    xs(0), 40'd34);
    check("t6_pulse", bus.spawn_pulse, 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
